// File: rtl/ec_pkg.sv
// Shared constants and state encoding for the elliptic-curve scalar sequencer.
package ec_pkg;
    localparam int KEY_W = 256;
    localparam int IDX_W = $clog2(KEY_W);

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_DOUBLE = 2'b01;
    localparam logic [1:0] OP_ADD    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DBL_REQ,
        ST_DBL_WAIT,
        ST_ADD_REQ,
        ST_ADD_WAIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/scalar_index_counter.sv
// Bit-index down-counter: loads to KEY_W-1, decrements on enable, wraps 0 -> KEY_W-1.
module scalar_index_counter #(
    parameter int KEY_W = 256,
    localparam int IDX_W = $clog2(KEY_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_is_zero
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(KEY_W - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || i_load)
            r_idx <= MAX_IDX;
        else if (i_dec)
            r_idx <= (r_idx == '0) ? MAX_IDX : r_idx - IDX_W'(1);
    end

    assign o_idx     = r_idx;
    assign o_is_zero = (r_idx == '0);
endmodule

// File: rtl/ec_scalar_sequencer.sv
// Double-and-add sequencer: walks scalar bits MSB-first, issuing DOUBLE/ADD requests.
// Optional LEADING_ZERO_SKIP_EN skips leading zero bits and starts with a lone ADD.
module ec_scalar_sequencer #(
    parameter int KEY_W = ec_pkg::KEY_W,
    localparam int IDX_W = $clog2(KEY_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] scalar,
    output logic             busy,
    output logic             op_valid,
    output logic [1:0]       op_code,
    input  logic             op_ready,
    input  logic             op_done,
    output logic [IDX_W-1:0] bit_idx,
    output logic             done,
    output logic             zero_scalar
);
    import ec_pkg::*;

    state_t           r_state;
    logic [KEY_W-1:0] r_shift;
    logic             r_busy, r_op_valid, r_done, r_zero, r_zero_flag;
    logic [1:0]       r_op_code;

    logic             w_bit, w_idx_zero, w_load, w_dec, w_advance, w_skip, w_step;
    logic [IDX_W-1:0] w_idx;

    assign w_bit     = r_shift[KEY_W-1];
    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_advance = ((r_state == ST_DBL_WAIT) && op_done && !w_bit) ||
                       ((r_state == ST_ADD_WAIT) && op_done);
`ifdef LEADING_ZERO_SKIP_EN
    assign w_skip    = (r_state == ST_SCAN) && !w_bit;
`else
    assign w_skip    = 1'b0;
`endif
    assign w_step    = w_advance || w_skip;
    // DONE decrements the spent counter so it wraps back to KEY_W-1 for the next job.
    assign w_dec     = (w_step && !w_idx_zero) || (r_state == ST_DONE);

    scalar_index_counter #(.KEY_W(KEY_W)) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_idx    (w_idx),
        .o_is_zero(w_idx_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_op_valid  <= 1'b0;
            r_op_code   <= OP_NONE;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_shift     <= scalar;
                    r_zero_flag <= (scalar == '0);
                    r_busy      <= 1'b1;
`ifdef LEADING_ZERO_SKIP_EN
                    r_state     <= ST_SCAN;
`else
                    r_state     <= ST_DBL_REQ;
                    r_op_valid  <= 1'b1;
                    r_op_code   <= OP_DOUBLE;
`endif
                end
`ifdef LEADING_ZERO_SKIP_EN
                // Accumulator is still infinity here, so the first set bit needs no DOUBLE.
                ST_SCAN: if (w_bit) begin
                    r_state    <= ST_ADD_REQ;
                    r_op_valid <= 1'b1;
                    r_op_code  <= OP_ADD;
                end
`endif
                ST_DBL_REQ: if (op_ready) begin
                    r_state    <= ST_DBL_WAIT;
                    r_op_valid <= 1'b0;
                    r_op_code  <= OP_NONE;
                end
                ST_DBL_WAIT: if (op_done && w_bit) begin
                    r_state    <= ST_ADD_REQ;
                    r_op_valid <= 1'b1;
                    r_op_code  <= OP_ADD;
                end
                ST_ADD_REQ: if (op_ready) begin
                    r_state    <= ST_ADD_WAIT;
                    r_op_valid <= 1'b0;
                    r_op_code  <= OP_NONE;
                end
                ST_ADD_WAIT: ;
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_zero  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_step) begin
                if (w_idx_zero) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_zero  <= r_zero_flag;
                end else begin
                    r_shift <= r_shift << 1;
                    if (w_advance) begin
                        r_state    <= ST_DBL_REQ;
                        r_op_valid <= 1'b1;
                        r_op_code  <= OP_DOUBLE;
                    end
                end
            end
        end
    end

    assign busy        = r_busy;
    assign op_valid    = r_op_valid;
    assign op_code     = r_op_code;
    assign bit_idx     = w_idx;
    assign done        = r_done;
    assign zero_scalar = r_zero;
endmodule

// File: tb/tb_ec_scalar_sequencer.sv
// Scoreboard bench for ec_scalar_sequencer: expected ops queued per job, monitor pops on handshake.
module tb_ec_scalar_sequencer;
    import ec_pkg::*;

    localparam int KW = 256;
    localparam int IW = 8;

`ifdef LEADING_ZERO_SKIP_EN
    localparam int ONE_D = 0,   ONE_A = 1;
    localparam int FIVE_D = 2,  FIVE_A = 2;
    localparam int ZERO_D = 0,  ZERO_A = 0;
    localparam int ALL_D = 255, ALL_A = 256;
    localparam logic [1:0] BP_CODE = 2'b10;
    localparam int BP_IDX = 2;
`else
    localparam int ONE_D = 256, ONE_A = 1;
    localparam int FIVE_D = 256, FIVE_A = 2;
    localparam int ZERO_D = 256, ZERO_A = 0;
    localparam int ALL_D = 256, ALL_A = 256;
    localparam logic [1:0] BP_CODE = 2'b01;
    localparam int BP_IDX = 255;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          op_ready = 1'b0, op_done = 1'b0;
    logic [KW-1:0] scalar = '0;
    logic          busy, op_valid, done, zero_scalar;
    logic [1:0]    op_code;
    logic [IW-1:0] bit_idx;

    typedef struct packed {
        logic [1:0]    code;
        logic [IW-1:0] idx;
    } op_t;

    op_t  exp_q[$];
    logic exp_zero_q[$];
    int   n_pass = 0, n_chk = 0;
    int   n_dbl = 0, n_add = 0, n_done = 0, lat_sel = 0;

    always #5 clk = ~clk;

    ec_scalar_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scalar(scalar),
        .busy(busy), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .op_done(op_done), .bit_idx(bit_idx),
        .done(done), .zero_scalar(zero_scalar)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endfunction

    function automatic void push_model(input logic [KW-1:0] k);
        bit started = 1'b0;
        for (int i = KW - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_SKIP_EN
            if (started) exp_q.push_back('{OP_DOUBLE, IW'(i)});
`else
            exp_q.push_back('{OP_DOUBLE, IW'(i)});
`endif
            if (k[i]) begin
                exp_q.push_back('{OP_ADD, IW'(i)});
                started = 1'b1;
            end
        end
        exp_zero_q.push_back(k == '0);
    endfunction

    // Monitor: every handshake and every done pulse is scored against the queues.
    initial forever begin
        @(negedge clk);
        if (rst_n && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL op_unexpected: got code %0d idx %0d with empty queue", op_code, bit_idx);
            end else begin
                op_t e;
                e = exp_q.pop_front();
                check("op_code", 32'(op_code), 32'(e.code));
                check("op_idx", 32'(bit_idx), 32'(e.idx));
                if (op_code == OP_DOUBLE) n_dbl++;
                else n_add++;
            end
        end
        if (rst_n && done) begin
            n_done++;
            if (exp_zero_q.size() == 0) begin
                n_chk++;
                $display("FAIL done_unexpected: got done with no job queued");
            end else begin
                check("zero_scalar", 32'(zero_scalar), 32'(exp_zero_q.pop_front()));
            end
            check("ops_left_at_done", 32'(exp_q.size()), 0);
            check("busy_at_done", 32'(busy), 1);
        end
    end

    // Point-unit model: completion pulse 0..2 cycles after the earliest legal cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n && op_valid && op_ready) begin
            @(posedge clk);
            repeat (lat_sel % 3) @(posedge clk);
            lat_sel++;
            #1 op_done = 1'b1;
            @(posedge clk);
            #1 op_done = 1'b0;
        end
    end

    task automatic pulse_start(input logic [KW-1:0] k);
        @(posedge clk); #1;
        start = 1'b1; scalar = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0, input int ed, input int ea);
        int c;
        for (c = 0; c < 8000 && n_done == d0; c++) @(posedge clk);
        if (n_done == d0) begin
            n_chk++;
            $display("FAIL %s_timeout: no done after %0d cycles", nm, c);
        end
        #1;
        check({nm, "_done_pulse"}, 32'(done), 0);
        check({nm, "_busy_off"}, 32'(busy), 0);
        check({nm, "_idx_wrap"}, 32'(bit_idx), 255);
        check({nm, "_n_dbl"}, 32'(n_dbl), 32'(ed));
        check({nm, "_n_add"}, 32'(n_add), 32'(ea));
    endtask

    task automatic run_job(input string nm, input logic [KW-1:0] k, input int ed, input int ea);
        int d0;
        push_model(k);
        n_dbl = 0; n_add = 0; d0 = n_done;
        pulse_start(k);
        wait_done(nm, d0, ed, ea);
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"}, 32'(busy), 0);
        check({nm, "_op_valid"}, 32'(op_valid), 0);
        check({nm, "_op_code"}, 32'(op_code), 0);
        check({nm, "_done"}, 32'(done), 0);
        check({nm, "_zero"}, 32'(zero_scalar), 0);
        check({nm, "_bit_idx"}, 32'(bit_idx), 255);
    endtask

    initial begin
        logic [KW-1:0] ones;
        int d0, c;
        ones = '1;

        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        rst_n = 1'b1;
        op_ready = 1'b1;

        run_job("one", KW'(1), ONE_D, ONE_A);
        run_job("five", KW'(5), FIVE_D, FIVE_A);
        run_job("zero", '0, ZERO_D, ZERO_A);
        run_job("ones", ones, ALL_D, ALL_A);

        // Back-pressure on the first request, plus a stray start and a stray op_done.
        push_model(KW'(5));
        n_dbl = 0; n_add = 0; d0 = n_done;
        op_ready = 1'b0;
        pulse_start(KW'(5));
        for (c = 0; c < 400 && !op_valid; c++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(op_valid), 1);
            check("bp_code", 32'(op_code), 32'(BP_CODE));
            check("bp_idx", 32'(bit_idx), 32'(BP_IDX));
            if (i == 0) begin
                op_done = 1'b1; start = 1'b1; scalar = ones;
            end else begin
                op_done = 1'b0; start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("bp_busy", 32'(busy), 1);
        op_ready = 1'b1;
        wait_done("bp", d0, FIVE_D, FIVE_A);

        // Reset mid-job once the index reaches 100.
        push_model(ones);
        pulse_start(ones);
        for (c = 0; c < 8000 && bit_idx != 8'd100; c++) begin
            @(posedge clk); #1;
        end
        check("rst_reach_100", 32'(bit_idx), 100);
        op_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle("midrst");
        rst_n = 1'b1;
        exp_q.delete();
        exp_zero_q.delete();
        repeat (6) @(posedge clk);
        #1 check_idle("post_rst");
        op_ready = 1'b1;

        run_job("recover", KW'(5), FIVE_D, FIVE_A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ec_scalar_sequencer.md
# ec_scalar_sequencer

Double-and-add control stage for the elliptic curve processor: it consumes a 256-bit scalar and walks its bits from index 255 down to 0. For each bit it issues DOUBLE and, when the bit is 1, ADD operation requests to the downstream point-arithmetic unit, over a valid/ready request plus a completion pulse. It keeps its own bit-index down-counter, which wraps 0 → 255 between jobs. It sits between the key-load logic and the point-arithmetic unit.

## Interface
- KEY_W, 256, scalar width; must be a power of two.
- IDX_W, $clog2(KEY_W) = 8, bit-index width; derived, not overridden.

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- start  in  1  job request; accepted only in IDLE
- scalar  in  KEY_W  scalar k; sampled on the accepted start cycle
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- op_valid  out  1  operation request valid
- op_code  out  2  2'b01 DOUBLE, 2'b10 ADD; 2'b00 when op_valid=0
- op_ready  in  1  downstream accepts the request when op_valid && op_ready
- op_done  in  1  one-cycle completion pulse from the point unit
- bit_idx  out  IDX_W  index of the bit currently being processed
- done  out  1  one-cycle pulse at job end
- zero_scalar  out  1  valid with done; 1 if scalar was 0

## Operation
- Bit selection:
  - The scalar is held in a shift register.
  - The current bit is its MSB; the register shifts left by 1 on each index decrement.
  - bit_idx decrements in lockstep.
- States: IDLE, SCAN (macro only), DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
- IDLE:
  - On start: load the scalar and set bit_idx=KEY_W-1.
  - Go to DBL_REQ, or to SCAN when the macro is enabled.
- DBL_REQ / ADD_REQ:
  - op_valid=1 with the matching op_code.
  - Hold both until op_ready, then go to the corresponding WAIT state.
- DBL_WAIT, on op_done:
  - If the current bit is 1, go to ADD_REQ.
  - Otherwise, advance.
- ADD_WAIT, on op_done: advance.
- Advance:
  - If bit_idx==0, go to DONE.
  - Otherwise decrement bit_idx, shift the register, and go to DBL_REQ.
- DONE:
  - done=1 for one cycle; zero_scalar reflects the loaded scalar.
  - Go to IDLE, with bit_idx wrapped to KEY_W-1.
- Ignored inputs:
  - start outside IDLE.
  - op_done outside the WAIT states.
  - op_ready while op_valid=0.
- Reset (including mid-job) takes effect the next cycle:
  - State goes to IDLE.
  - bit_idx=KEY_W-1, scalar register=0.
  - busy, op_valid, op_code, done and zero_scalar all 0.
  - No partial request remains outstanding.

## Timing
- Start latency: start accepted at cycle N → op_valid=1 at N+1 (no macro).
- Request/completion:
  - The request handshake completes at cycle H.
  - The earliest honoured op_done is at H+1.
  - The next op_valid follows one cycle after the op_done cycle.
- Back-pressure: op_code and bit_idx are stable while op_valid=1 && op_ready=0.
- SCAN consumes one cycle per skipped leading zero bit.
- All outputs are registered.

## Configuration
- LEADING_ZERO_SKIP_EN defined:
  - SCAN decrements bit_idx, one per cycle, while the current bit is 0, issuing no ops.
  - At the first set bit, issue ADD only (the accumulator is infinity), then continue normally at the next index.
  - Scalar 0: no ops are issued; DONE with zero_scalar=1 after KEY_W SCAN cycles.
- LEADING_ZERO_SKIP_EN undefined:
  - Every index from 255 down to 0 issues a DOUBLE.
  - Scalar 0: 256 DOUBLEs, then DONE with zero_scalar=1.

## Structure
- Shared package ec_pkg:
  - KEY_W.
  - op_code localparams OP_NONE, OP_DOUBLE, OP_ADD.
  - State enum type.
- One sub-module, scalar_index_counter:
  - Load-to-max, decrement-with-enable.
  - Wraps 0→max; exposes an is_zero flag.

## Test plan
- scalar=1, macro off → 256 DOUBLEs with bit_idx 255..0, then one ADD at idx 0; done, zero_scalar=0.
- scalar=1, macro on → SCAN 255 cycles, one ADD at idx 0, done; no DOUBLE.
- scalar=0x5, macro on → op sequence ADD(idx2), DBL(1), DBL(0), ADD(0), then done.
- All-ones scalar → macro off: 256 DBL + 256 ADD; macro on: 255 DBL + 256 ADD.
- op_ready low for 3 cycles in DBL_REQ → op_valid, op_code=01 and bit_idx held constant; the op is issued exactly once.
- Robustness:
  - rst_n low mid-job at bit_idx=100 → next cycle IDLE, all outputs 0, bit_idx=255.
  - start during busy and a spurious op_done in DBL_REQ → both ignored, with no extra ops.
